// File: rtl/floatingpoint_divider.sv
// ---------------------------------------------------------------------------
// floatingpoint_divider
//   Multi-cycle IEEE-754 single-precision divider (A / B). The mantissas are
//   divided with a bit-serial restoring divider. The result is truncated and
//   never rounded. Denormal operands are flushed to zero.
//
//   Latency is fixed. The accepting edge moves the FSM to PREP. PREP takes
//   1 edge, DIV takes 25 edges and NORM takes 1 edge. done_o is therefore high
//   in the cycle after the 27th edge that follows acceptance. Special cases
//   take the same path, so the latency does not depend on the operands.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_n_i      : asynchronous active-low reset
//   start_i      : request a division (sampled only in IDLE)
//   dataA_i      : dividend (captured on the accepting edge)
//   dataB_i      : divisor  (captured on the accepting edge)
//   data_o       : registered quotient, held between results
//   busy_o       : high from the accepting edge until the edge that raises done_o
//   done_o       : one-cycle pulse marking data_o valid
//   dbg_state_o  : current FSM state (0 IDLE, 1 PREP, 2 DIV, 3 NORM)
//
// Handshake: a request is taken on any rising edge where the FSM is in IDLE
// and start_i=1. start_i and the operand inputs are ignored in every other
// state. A new request may be made in the cycle that done_o is high.
// ---------------------------------------------------------------------------
module floatingpoint_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] dataA_i,
    input  logic [DATA_WIDTH-1:0] dataB_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [1:0]            dbg_state_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_NORM = 2'd3;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_sign;
    logic signed [9:0]     r_exp;
    logic [23:0]           r_mant_b;
    logic [25:0]           r_rem;
    logic [24:0]           r_q;
    logic [4:0]            r_cnt;
    logic                  r_special;
    logic [31:0]           r_special_val;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_done;

    // ---- operand classification (used in PREP) ----
    logic [7:0]        w_exp_a, w_exp_b;
    logic              w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;
    logic              w_sign;
    logic signed [9:0] w_exp_diff;
    logic              w_special;
    logic [31:0]       w_special_val;

    assign w_exp_a    = r_a[30:23];
    assign w_exp_b    = r_b[30:23];
    assign w_zero_a   = (w_exp_a == 8'h00);
    assign w_zero_b   = (w_exp_b == 8'h00);
    assign w_inf_a    = (w_exp_a == 8'hFF) && (r_a[22:0] == 23'd0);
    assign w_inf_b    = (w_exp_b == 8'hFF) && (r_b[22:0] == 23'd0);
    assign w_nan_a    = (w_exp_a == 8'hFF) && (r_a[22:0] != 23'd0);
    assign w_nan_b    = (w_exp_b == 8'hFF) && (r_b[22:0] != 23'd0);
    assign w_sign     = r_a[31] ^ r_b[31];
    assign w_exp_diff = $signed({2'b00, w_exp_a}) - $signed({2'b00, w_exp_b});

    // The checks are listed in priority order. The NaN result is canonical
    // and does not carry a sign. Infinity and zero take the computed sign.
    always_comb begin
        w_special     = 1'b1;
        w_special_val = QNAN;
        if (w_nan_a || w_nan_b || (w_zero_a && w_zero_b) || (w_inf_a && w_inf_b)) begin
            w_special_val = QNAN;
        end else if (w_inf_a || w_zero_b) begin
            w_special_val = {w_sign, 8'hFF, 23'd0};
        end else if (w_zero_a || w_inf_b) begin
            w_special_val = {w_sign, 31'd0};
        end else begin
            w_special     = 1'b0;
        end
    end

    // ---- restoring divide step ----
    // The remainder is always below 2*mant_b. After the left shift it fits
    // in 26 bits.
    logic w_ge;
    assign w_ge = (r_rem >= {2'b00, r_mant_b});

    // ---- normalisation (used in NORM) ----
    logic signed [9:0] w_exp_norm;
    logic [22:0]       w_frac;
    logic [31:0]       w_result;

    assign w_exp_norm = r_q[24] ? (r_exp + 10'sd127) : (r_exp + 10'sd126);
    assign w_frac     = r_q[24] ? r_q[23:1] : r_q[22:0];

    always_comb begin
        w_result = {r_sign, w_exp_norm[7:0], w_frac};
        if (r_special) begin
            w_result = r_special_val;
        end else if (w_exp_norm >= 10'sd255) begin
            w_result = {r_sign, 8'hFF, 23'd0};
        end else if (w_exp_norm <= 10'sd0) begin
            w_result = {r_sign, 31'd0};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state       <= S_IDLE;
            r_a           <= '0;
            r_b           <= '0;
            r_sign        <= 1'b0;
            r_exp         <= '0;
            r_mant_b      <= '0;
            r_rem         <= '0;
            r_q           <= '0;
            r_cnt         <= '0;
            r_special     <= 1'b0;
            r_special_val <= '0;
            r_data        <= '0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_a     <= dataA_i;
                        r_b     <= dataB_i;
                        r_state <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_sign        <= w_sign;
                    r_exp         <= w_exp_diff;
                    r_mant_b      <= {1'b1, r_b[22:0]};
                    r_rem         <= {3'b001, r_a[22:0]};
                    r_q           <= '0;
                    r_cnt         <= '0;
                    r_special     <= w_special;
                    r_special_val <= w_special_val;
                    r_state       <= S_DIV;
                end
                S_DIV: begin
                    r_q   <= {r_q[23:0], w_ge};
                    r_rem <= (w_ge ? (r_rem - {2'b00, r_mant_b}) : r_rem) << 1;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd24) begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    r_data  <= w_result;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_o      = r_data;
    assign done_o      = r_done;
    assign busy_o      = (r_state != S_IDLE);
    assign dbg_state_o = r_state;

endmodule
